// File: rtl/axicb_slv_switch_rd.sv
// Slave-side AXI read switch: decodes ARADDR to one of SLV_NB slaves (or an internal DECERR responder)
// and arbitrates R bursts back to the master round-robin, with the grant locked for the whole burst.
module axicb_slv_switch_rd #(
  parameter int AXI_ADDR_W = 16,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 8,
  parameter int SLV_NB     = 4,
  parameter logic [AXI_ADDR_W-1:0] SLV0_START_ADDR = 'h0000,
  parameter logic [AXI_ADDR_W-1:0] SLV0_END_ADDR   = 'h0FFF,
  parameter logic [AXI_ADDR_W-1:0] SLV1_START_ADDR = 'h1000,
  parameter logic [AXI_ADDR_W-1:0] SLV1_END_ADDR   = 'h1FFF,
  parameter logic [AXI_ADDR_W-1:0] SLV2_START_ADDR = 'h2000,
  parameter logic [AXI_ADDR_W-1:0] SLV2_END_ADDR   = 'h2FFF,
  parameter logic [AXI_ADDR_W-1:0] SLV3_START_ADDR = 'h3000,
  parameter logic [AXI_ADDR_W-1:0] SLV3_END_ADDR   = 'h3FFF,
  parameter int ARCH_W = AXI_ID_W + AXI_ADDR_W + 8 + 13,
  parameter int RCH_W  = AXI_ID_W + AXI_DATA_W + 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic                    i_arvalid,
  output logic                    i_arready,
  input  logic [ARCH_W-1:0]       i_arch,
  output logic                    i_rvalid,
  input  logic                    i_rready,
  output logic                    i_rlast,
  output logic [RCH_W-1:0]        i_rch,
  output logic [SLV_NB-1:0]       o_arvalid,
  input  logic [SLV_NB-1:0]       o_arready,
  output logic [ARCH_W-1:0]       o_arch,
  input  logic [SLV_NB-1:0]       o_rvalid,
  output logic [SLV_NB-1:0]       o_rready,
  input  logic [SLV_NB-1:0]       o_rlast,
  input  logic [SLV_NB*RCH_W-1:0] o_rch
);

  localparam int NSRC = SLV_NB + 1;
  localparam int SW   = $clog2(NSRC);

  typedef enum logic {DEC_IDLE, DEC_RESP} dec_state_t;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;

  logic [AXI_ADDR_W-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [AXI_ID_W-1:0]   ar_id;
  logic [AXI_ADDR_W-1:0] win_lo [4];
  logic [AXI_ADDR_W-1:0] win_hi [4];
  logic [SLV_NB-1:0]     ar_sel;
  logic                  ar_miss;

  assign ar_id   = i_arch[0 +: AXI_ID_W];
  assign ar_addr = i_arch[AXI_ID_W +: AXI_ADDR_W];
  assign ar_len  = i_arch[AXI_ID_W+AXI_ADDR_W +: 8];

  assign win_lo[0] = SLV0_START_ADDR;
  assign win_hi[0] = SLV0_END_ADDR;
  assign win_lo[1] = SLV1_START_ADDR;
  assign win_hi[1] = SLV1_END_ADDR;
  assign win_lo[2] = SLV2_START_ADDR;
  assign win_hi[2] = SLV2_END_ADDR;
  assign win_lo[3] = SLV3_START_ADDR;
  assign win_hi[3] = SLV3_END_ADDR;

  // Lowest index wins when windows overlap: only the first hit sets a select bit.
  always_comb begin
    ar_sel = '0;
    for (int x = 0; x < SLV_NB; x++) begin
      if (!(|ar_sel) && ar_addr >= win_lo[x] && ar_addr <= win_hi[x]) ar_sel[x] = 1'b1;
    end
  end

  assign ar_miss   = ~(|ar_sel);
  assign o_arvalid = {SLV_NB{i_arvalid}} & ar_sel;
  assign o_arch    = i_arch;

  // DECERR responder
  dec_state_t            dec_state_q, dec_state_d;
  logic [AXI_ID_W-1:0]   dec_id_q, dec_id_d;
  logic [7:0]            dec_len_q, dec_len_d;
  logic [7:0]            dec_cnt_q, dec_cnt_d;
  logic                  dec_rvalid, dec_rlast, dec_rready;

  assign dec_rvalid = (dec_state_q == DEC_RESP);
  assign dec_rlast  = dec_rvalid && (dec_cnt_q == dec_len_q);
  assign i_arready  = ar_miss ? (dec_state_q == DEC_IDLE) : |(o_arready & ar_sel);

  always_comb begin
    dec_state_d = dec_state_q;
    dec_id_d    = dec_id_q;
    dec_len_d   = dec_len_q;
    dec_cnt_d   = dec_cnt_q;
    case (dec_state_q)
      DEC_IDLE: begin
        if (i_arvalid && ar_miss) begin
          dec_state_d = DEC_RESP;
          dec_id_d    = ar_id;
          dec_len_d   = ar_len;
          dec_cnt_d   = '0;
        end
      end
      DEC_RESP: begin
        if (dec_rready) begin
          if (dec_rlast) dec_state_d = DEC_IDLE;
          else           dec_cnt_d   = dec_cnt_q + 8'd1;
        end
      end
      default: dec_state_d = DEC_IDLE;
    endcase
    if (srst) begin
      dec_state_d = DEC_IDLE;
      dec_id_d    = '0;
      dec_len_d   = '0;
      dec_cnt_d   = '0;
    end
  end

  // R arbitration: slaves at 0..SLV_NB-1, DECERR responder at SLV_NB
  r_state_t         r_state_q, r_state_d;
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]    gnt_q, gnt_d;
  logic [NSRC-1:0]  src_vld, src_last, src_rdy;
  logic [RCH_W-1:0] src_dat [NSRC];
  logic [SW-1:0]    rr_pick, gnt, nxt_ptr;
  logic             rr_found, gnt_vld, r_hs;

  assign src_vld  = {dec_rvalid, o_rvalid};
  assign src_last = {dec_rlast, o_rlast};

  always_comb begin
    for (int x = 0; x < SLV_NB; x++) src_dat[x] = o_rch[x*RCH_W +: RCH_W];
    src_dat[SLV_NB] = {2'b11, {AXI_DATA_W{1'b0}}, dec_id_q};
  end

  always_comb begin
    int idx;
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!rr_found && src_vld[idx]) begin
        rr_found = 1'b1;
        rr_pick  = SW'(idx);
      end
    end
  end

  assign gnt     = (r_state_q == R_BURST) ? gnt_q : rr_pick;
  assign gnt_vld = (r_state_q == R_BURST) || rr_found;

  always_comb begin
    for (int x = 0; x < NSRC; x++) src_rdy[x] = gnt_vld && (gnt == SW'(x)) && i_rready;
  end

  assign o_rready   = src_rdy[SLV_NB-1:0];
  assign dec_rready = src_rdy[SLV_NB];
  assign i_rvalid   = gnt_vld && src_vld[gnt];
  assign i_rlast    = gnt_vld && src_last[gnt];
  assign i_rch      = gnt_vld ? src_dat[gnt] : '0;
  assign r_hs       = i_rvalid && i_rready;
  assign nxt_ptr    = (gnt == SW'(NSRC-1)) ? '0 : gnt + 1'b1;

  always_comb begin
    r_state_d = r_state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    if (r_hs) begin
      if (i_rlast) begin
        r_state_d = R_IDLE;
        rr_ptr_d  = nxt_ptr;
      end else begin
        r_state_d = R_BURST;
        gnt_d     = gnt;
      end
    end
    if (srst) begin
      r_state_d = R_IDLE;
      rr_ptr_d  = '0;
      gnt_d     = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dec_state_q <= DEC_IDLE;
      dec_id_q    <= '0;
      dec_len_q   <= '0;
      dec_cnt_q   <= '0;
      r_state_q   <= R_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
    end else begin
      dec_state_q <= dec_state_d;
      dec_id_q    <= dec_id_d;
      dec_len_q   <= dec_len_d;
      dec_cnt_q   <= dec_cnt_d;
      r_state_q   <= r_state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
    end
  end

endmodule

// File: tb/tb_axicb_slv_switch_rd.sv
// Randomized bench for axicb_slv_switch_rd: slaves and master are modelled here, and every
// cycle the DUT outputs are compared with a transaction-level model of decode, DECERR and arbitration.
module tb_axicb_slv_switch_rd;

  localparam int AW = 16, IW = 8, DW = 8, NS = 4, NSRC = 5;
  localparam int ARCH_W = IW + AW + 8 + 13;
  localparam int RCH_W  = IW + DW + 2;

  logic                  aclk = 1'b0, aresetn = 1'b0, srst = 1'b0;
  logic                  i_arvalid = 1'b0, i_arready;
  logic [ARCH_W-1:0]     i_arch = '0;
  logic                  i_rvalid, i_rready = 1'b0, i_rlast;
  logic [RCH_W-1:0]      i_rch;
  logic [NS-1:0]         o_arvalid, o_arready = '0;
  logic [ARCH_W-1:0]     o_arch;
  logic [NS-1:0]         o_rvalid = '0, o_rready, o_rlast = '0;
  logic [NS*RCH_W-1:0]   o_rch = '0;

  axicb_slv_switch_rd dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch)
  );

  always #5 aclk = ~aclk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model state
  int       ptr, lock;
  bit       dec_busy;
  int       dec_id, dec_len, dec_cnt, dec_beats;
  int       pend [NS][$];     // id*256+len per accepted AR
  int       beat [NS];
  logic [DW-1:0] cur_dat [NS];
  int       long_dec_done = 0;

  task automatic model_reset();
    ptr = 0; lock = -1; dec_busy = 0; dec_id = 0; dec_len = 0; dec_cnt = 0; dec_beats = 0;
    for (int x = 0; x < NS; x++) begin
      pend[x].delete();
      beat[x] = 0;
      cur_dat[x] = '0;
    end
  endtask

  task automatic idle_inputs();
    i_arvalid = 0; i_arch = '0; o_arready = '0; o_rvalid = '0; o_rlast = '0; o_rch = '0; i_rready = 0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_arvalid"}, 64'(o_arvalid), 64'h0);
    chk({tag, "_arready"}, 64'(i_arready), 64'h0);
    chk({tag, "_rvalid"},  64'(i_rvalid),  64'h0);
    chk({tag, "_rlast"},   64'(i_rlast),   64'h0);
    chk({tag, "_rch"},     64'(i_rch),     64'h0);
    chk({tag, "_rready"},  64'(o_rready),  64'h0);
  endtask

  task automatic run_cycle();
    int sel, g, idx, id, len;
    logic [AW-1:0] addr;
    logic [NSRC-1:0] v, lst;
    logic [RCH_W-1:0] p [NSRC];
    logic [RCH_W-1:0] drv;
    bit miss_pick, ar_rdy_exp;

    @(negedge aclk);
    // master AR
    miss_pick = ($urandom_range(0, 99) < 25);
    addr = miss_pick ? AW'($urandom_range('h4000, 'hFFFF))
                     : AW'(($urandom_range(0, 3) << 12) | $urandom_range(0, 'hFFF));
    len  = (miss_pick && $urandom_range(0, 11) == 0) ? 255 : $urandom_range(0, 3);
    id   = $urandom_range(0, 255);
    i_arvalid = ($urandom_range(0, 99) < 50);
    i_arch    = {13'($urandom), 8'(len), addr, 8'(id)};
    o_arready = 4'($urandom);
    i_rready  = ($urandom_range(0, 99) < 70);
    // slaves R
    for (int x = 0; x < NS; x++) begin
      if (pend[x].size() > 0) begin
        o_rvalid[x] = ($urandom_range(0, 99) < 75);
        o_rlast[x]  = (beat[x] == (pend[x][0] & 255));
        drv = {2'(x), cur_dat[x], 8'(pend[x][0] >> 8)};
      end else begin
        o_rvalid[x] = 0;
        o_rlast[x]  = 0;
        drv = '0;
      end
      o_rch[x*RCH_W +: RCH_W] = drv;
    end
    #1;

    // decode expectations
    sel = -1;
    for (int x = NS - 1; x >= 0; x--)
      if (int'(addr) >= x * 'h1000 && int'(addr) <= x * 'h1000 + 'hFFF) sel = x;
    ar_rdy_exp = (sel >= 0) ? o_arready[sel] : !dec_busy;
    chk("ar_vld", 64'(o_arvalid), (i_arvalid && sel >= 0) ? 64'(1 << sel) : 64'h0);
    chk("ar_rdy", 64'(i_arready), 64'(ar_rdy_exp));
    chk("ar_ch",  64'(o_arch),    64'(i_arch));

    // arbitration expectations
    for (int x = 0; x < NS; x++) begin
      v[x] = o_rvalid[x];
      lst[x] = o_rlast[x];
      p[x] = o_rch[x*RCH_W +: RCH_W];
    end
    v[NS] = dec_busy;
    lst[NS] = dec_busy && (dec_cnt == dec_len);
    p[NS] = {2'b11, 8'h00, 8'(dec_id)};
    g = lock;
    if (g < 0)
      for (int k = 0; k < NSRC; k++) begin
        idx = (ptr + k) % NSRC;
        if (g < 0 && v[idx]) g = idx;
      end
    chk("r_vld",  64'(i_rvalid), (g >= 0) ? 64'(v[g]) : 64'h0);
    chk("r_last", 64'(i_rlast),  (g >= 0) ? 64'(lst[g]) : 64'h0);
    chk("r_ch",   64'(i_rch),    (g >= 0) ? 64'(p[g]) : 64'h0);
    chk("r_rdy",  64'(o_rready), (g >= 0 && g < NS && i_rready) ? 64'(1 << g) : 64'h0);

    // advance model for the coming edge
    if (i_arvalid && ar_rdy_exp) begin
      if (sel >= 0) pend[sel].push_back(id * 256 + len);
      else begin
        dec_busy = 1; dec_id = id; dec_len = len; dec_cnt = 0; dec_beats = 0;
      end
    end
    if (g >= 0 && v[g] && i_rready) begin
      if (g < NS) begin
        cur_dat[g] = DW'($urandom);
        if (lst[g]) begin
          beat[g] = 0;
          void'(pend[g].pop_front());
        end else beat[g]++;
      end else begin
        dec_beats++;
        if (lst[g]) begin
          dec_busy = 0;
          if (dec_len == 255 && dec_beats == 256) long_dec_done++;
        end else dec_cnt++;
      end
      if (lst[g]) begin
        lock = -1;
        ptr = (g + 1) % NSRC;
      end else lock = g;
    end
  endtask

  initial begin
    model_reset();
    idle_inputs();
    #2;
    check_quiet("rst");
    @(negedge aclk);
    aresetn = 1;
    for (int c = 0; c < 9000; c++) begin
      if (c == 3000) begin
        // async reset mid-traffic: outputs must drop without waiting for an edge
        @(negedge aclk);
        idle_inputs();
        aresetn = 0;
        #1;
        check_quiet("arst");
        model_reset();
        @(negedge aclk);
        aresetn = 1;
      end else if (c == 6000) begin
        @(negedge aclk);
        idle_inputs();
        srst = 1;
        @(negedge aclk);
        check_quiet("srst");
        srst = 0;
        model_reset();
      end else begin
        run_cycle();
      end
    end
    chk("long_decerr_seen", 64'(long_dec_done > 0), 64'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
